divisor_sequencial: RTL and testbench

Sequential unsigned restoring divider: computes quotient and remainder of A ÷ B by repeated trial subtraction, one quotient bit per clock. The trial subtraction uses the same borrow convention as the datapath's subtractor: borrow = 1 when the minuend is smaller than the subtrahend. The block sits beside the combinational add/subtract units in the arithmetic datapath and is driven by the same controller through a start/done handshake.

---
 rtl/divisor_sequencial_pkg.sv | 18 +
 rtl/divisor_sequencial_if.sv | 18 +
 rtl/divisor_sequencial_subtrator.sv | 14 +
 rtl/divisor_sequencial.sv | 134 +++++++++++++
 tb/tb_divisor_sequencial.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_sequencial_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divisor_sequencial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT);

  // Step counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divisor_sequencial_if.sv
// Start/done handshake and operand/result bus between controller and divider.
interface divisor_sequencial_if
  import divisor_sequencial_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         div_zero;

  modport master (output start, A, B, input Q, R, busy, done, div_zero);
  modport slave  (input start, A, B, output Q, R, busy, done, div_zero);
endinterface

// File: rtl/divisor_sequencial_subtrator.sv
// One trial-subtraction stage: diff = p - b via p + ~b + 1, borrow = ~carry.
module estagio_subtrator #(
  parameter int W = 5
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic carry;

  assign {carry, diff} = {1'b0, p} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign borrow        = ~carry;
endmodule

// File: rtl/divisor_sequencial.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIVZERO_FLAG_EN: detect B=0 at accept, report div_zero with 1-edge latency.
module divisor_sequencial
  import divisor_sequencial_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  divisor_sequencial_if.slave bus
);
  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd, dvs, q_int;
  logic [N-1:0]  q_reg, r_reg;
  logic [N:0]    p, shifted, trial, p_nx;
  logic          brw, accept, zero_acc, zero_pend, last;

  // The partial remainder's top bit and the oldest quotient bit shift out by construction.
  logic unused_bits;
  assign unused_bits = ^{p[N], q_int[N-1]};

  assign shifted = {p[N-1:0], dvd[N-1]};

  estagio_subtrator #(.W(N + 1)) u_sub (
    .p      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .borrow (brw)
  );

  assign p_nx = brw ? shifted : trial;
  assign last = (state == CALC) && (cnt == '0);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    zero_acc = 1'b0;
    case (state)
      IDLE: if (bus.start) accept = 1'b1;
      CALC: if (cnt == '0) state_nx = DONE;
      DONE: begin
        // While a zero-divisor result is pending, the handshake is not yet complete.
        if (!zero_pend) begin
          if (bus.start) accept = 1'b1;
          else           state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      state_nx = CALC;
`ifdef DIVZERO_FLAG_EN
      if (bus.B == '0) begin
        zero_acc = 1'b1;
        state_nx = DONE;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      zero_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      zero_pend <= zero_acc;
      if (accept)                        cnt <= CNT_LOAD;
      else if (state == CALC && cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  // Datapath registers: loaded at accept, advanced once per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd   <= bus.A;
      dvs   <= bus.B;
      p     <= '0;
      q_int <= '0;
    end else if (state == CALC) begin
      dvd   <= {dvd[N-2:0], 1'b0};
      p     <= p_nx;
      q_int <= {q_int[N-2:0], ~brw};
    end
  end

`ifdef DIVZERO_FLAG_EN
  logic dz_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg  <= '0;
      r_reg  <= '0;
      dz_reg <= 1'b0;
    end else begin
      if (last) begin
        q_reg <= {q_int[N-2:0], ~brw};
        r_reg <= p_nx[N-1:0];
      end
      if (accept && !zero_acc) dz_reg <= 1'b0;
      if (state == DONE && zero_pend) begin
        q_reg  <= '1;
        r_reg  <= dvd;
        dz_reg <= 1'b1;
      end
    end
  end

  assign bus.div_zero = dz_reg;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
      r_reg <= '0;
    end else if (last) begin
      q_reg <= {q_int[N-2:0], ~brw};
      r_reg <= p_nx[N-1:0];
    end
  end

  assign bus.div_zero = 1'b0;
`endif

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.busy = (state == CALC);
  assign bus.done = (state == DONE) && !zero_pend;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Randomized and directed bench for divisor_sequencial against an arithmetic reference model.
module tb_divisor_sequencial;
  localparam int N = 4;

`ifdef DIVZERO_FLAG_EN
  localparam int ZFLAG = 1;
`else
  localparam int ZFLAG = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  divisor_sequencial_if #(.N(N)) bus();
  divisor_sequencial #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: quotient/remainder by plain arithmetic; edges from accept to done.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int lat);
    if (b == 0) begin
      q = (1 << N) - 1; r = a; dz = ZFLAG; lat = (ZFLAG != 0) ? 1 : N;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = N;
    end
  endfunction

  task automatic issue(input int a, input int b);
    @(negedge clk);
    bus.A = N'(a); bus.B = N'(b); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges = -1; busy_cnt = 0;
    for (int e = 0; e <= 3 * N + 4; e++) begin
      if (bus.done === 1'b1) begin
        edges = e;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.Q, bus.R, bus.busy, bus.done, bus.div_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: Q=%0d R=%0d busy=%b done=%b dz=%b, required all 0",
               bus.Q, bus.R, bus.busy, bus.done, bus.div_zero);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int e, bc;
    issue(13, 3);
    wait_done(e, bc);
    n_checks++;
    if (e !== N) begin n_fail++; $display("FAIL basic_latency: %0d edges, required %0d", e, N); end
    n_checks++;
    if (bc !== N) begin n_fail++; $display("FAIL basic_busy: %0d cycles, required %0d", bc, N); end
    n_checks++;
    if (bus.Q !== 4'd4 || bus.R !== 4'd1 || bus.div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_13_3: Q=%0d R=%0d dz=%b, required Q=4 R=1 dz=0", bus.Q, bus.R, bus.div_zero);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Q !== 4'd4 || bus.R !== 4'd1) begin
      n_fail++;
      $display("FAIL done_pulse_hold: done=%b busy=%b Q=%0d R=%0d, required 0 0 4 1",
               bus.done, bus.busy, bus.Q, bus.R);
    end
  endtask

  task automatic test_directed();
    int ta[2] = '{7, 15};
    int tbv[2] = '{9, 1};
    int e, bc, q, r, dz, lat;
    for (int i = 0; i < 2; i++) begin
      model(ta[i], tbv[i], q, r, dz, lat);
      issue(ta[i], tbv[i]);
      wait_done(e, bc);
      n_checks++;
      if (e !== lat || bus.Q !== N'(q) || bus.R !== N'(r)) begin
        n_fail++;
        $display("FAIL directed_%0d_%0d: edges=%0d Q=%0d R=%0d, required edges=%0d Q=%0d R=%0d",
                 ta[i], tbv[i], e, bus.Q, bus.R, lat, q, r);
      end
    end
  endtask

  task automatic test_div_zero();
    int e, bc, q, r, dz, lat;
    model(6, 0, q, r, dz, lat);
    issue(6, 0);
    wait_done(e, bc);
    n_checks++;
    if (e !== lat) begin n_fail++; $display("FAIL zero_latency: %0d edges, required %0d", e, lat); end
    n_checks++;
    if (bc !== ((ZFLAG != 0) ? 0 : N)) begin
      n_fail++;
      $display("FAIL zero_busy: %0d busy cycles, required %0d", bc, (ZFLAG != 0) ? 0 : N);
    end
    n_checks++;
    if (bus.Q !== N'(q) || bus.R !== N'(r) || bus.div_zero !== dz[0]) begin
      n_fail++;
      $display("FAIL zero_result: Q=%0d R=%0d dz=%b, required Q=%0d R=%0d dz=%0d",
               bus.Q, bus.R, bus.div_zero, q, r, dz);
    end
    issue(5, 2);
    wait_done(e, bc);
    n_checks++;
    if (bus.div_zero !== 1'b0 || bus.Q !== 4'd2 || bus.R !== 4'd1) begin
      n_fail++;
      $display("FAIL zero_clear: dz=%b Q=%0d R=%0d, required dz=0 Q=2 R=1", bus.div_zero, bus.Q, bus.R);
    end
  endtask

  task automatic test_start_ignored();
    int e, bc;
    issue(13, 3);
    bus.A = 4'd2; bus.B = 4'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(e, bc);
    n_checks++;
    if (e !== N - 1 || bus.Q !== 4'd4 || bus.R !== 4'd1) begin
      n_fail++;
      $display("FAIL start_ignored: edges=%0d Q=%0d R=%0d, required edges=%0d Q=4 R=1",
               e, bus.Q, bus.R, N - 1);
    end
    bc = 0;
    repeat (N + 2) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b1 || bus.done === 1'b1) bc++;
    end
    n_checks++;
    if (bc !== 0) begin n_fail++; $display("FAIL no_queue: %0d active cycles, required 0", bc); end
  endtask

  task automatic test_async_reset();
    int e, bc;
    issue(13, 3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.Q, bus.R, bus.busy, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: Q=%0d R=%0d busy=%b done=%b, required all 0",
               bus.Q, bus.R, bus.busy, bus.done);
    end
    @(negedge clk) rst = 1'b0;
    issue(9, 2);
    wait_done(e, bc);
    n_checks++;
    if (e !== N || bus.Q !== 4'd4 || bus.R !== 4'd1) begin
      n_fail++;
      $display("FAIL after_reset_9_2: edges=%0d Q=%0d R=%0d, required edges=%0d Q=4 R=1", e, bus.Q, bus.R, N);
    end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    @(negedge clk);
    bus.A = 4'd12; bus.B = 4'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(e, bc);
    n_checks++;
    if (e !== N || bus.Q !== 4'd2 || bus.R !== 4'd2) begin
      n_fail++;
      $display("FAIL b2b_first: edges=%0d Q=%0d R=%0d, required edges=%0d Q=2 R=2", e, bus.Q, bus.R, N);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", bus.done, bus.busy);
    end
    wait_done(e, bc);
    n_checks++;
    if (e !== N || bus.Q !== 4'd2 || bus.R !== 4'd2) begin
      n_fail++;
      $display("FAIL b2b_second: edges=%0d Q=%0d R=%0d, required edges=%0d Q=2 R=2", e, bus.Q, bus.R, N);
    end
  endtask

  task automatic test_sweep();
    int e, bc, q, r, dz, lat;
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 1; b < (1 << N); b++) begin
        model(a, b, q, r, dz, lat);
        issue(a, b);
        wait_done(e, bc);
        n_checks++;
        if (e !== lat || bus.Q !== N'(q) || bus.R !== N'(r) || bus.div_zero !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_%0d_%0d: edges=%0d Q=%0d R=%0d dz=%b, required edges=%0d Q=%0d R=%0d dz=0",
                   a, b, e, bus.Q, bus.R, bus.div_zero, lat, q, r);
        end
        n_checks++;
        if (int'(bus.Q) * b + int'(bus.R) != a || int'(bus.R) >= b) begin
          n_fail++;
          $display("FAIL invariant_%0d_%0d: Q=%0d R=%0d, required A=Q*B+R and R<B", a, b, bus.Q, bus.R);
        end
      end
    end
  endtask

  task automatic test_random();
    int e, bc, q, r, dz, lat, a, b;
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      model(a, b, q, r, dz, lat);
      issue(a, b);
      wait_done(e, bc);
      n_checks++;
      if (e !== lat || bus.Q !== N'(q) || bus.R !== N'(r) || bus.div_zero !== dz[0]) begin
        n_fail++;
        $display("FAIL random_%0d_%0d: edges=%0d Q=%0d R=%0d dz=%b, required edges=%0d Q=%0d R=%0d dz=%0d",
                 a, b, e, bus.Q, bus.R, bus.div_zero, lat, q, r, dz);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_div_zero();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
